bus_flag_latch: RTL and testbench
=================================

BUS_FLAG_LATCH -- requirements
Module: bus_flag_latch

Interface
REQ-001 Parameter WIDTH, default 8: width of the stored register and of both buses.
REQ-002 Parameter PER_BIT_EN, default 0. 0 = single load enable (bus-register mode). 1 = independent per-bit load enables (flag-register mode).
REQ-003 Port ph1, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of ph1.
REQ-005 Port in_en, input, WIDTH bits: load enable. With PER_BIT_EN=0 only bit 0 is used; bits WIDTH-1..1 are ignored. With PER_BIT_EN=1, bit i enables loading of stored bit i.
REQ-006 Port out_en, input, 1 bit: output enable onto x_bus.
REQ-007 Port value, output, WIDTH bits: the stored register contents, always driven.
REQ-008 Port y_bus, input, WIDTH bits: the source data to be loaded.
REQ-009 Port x_bus, inout (tri-state), WIDTH bits: the shared destination bus.

Function
REQ-010 The block shall hold a WIDTH-bit register R; value shall equal R at all times.
REQ-011 PER_BIT_EN=0: at a ph1 rising edge with reset=0 and in_en[0]=1, R shall become y_bus; with in_en[0]=0, R shall hold.
REQ-012 PER_BIT_EN=1: at a ph1 rising edge with reset=0, each bit R[i] shall become y_bus[i] where in_en[i]=1, and all other bits shall hold.
REQ-013 Load latency shall be one edge: the new R is visible on value and x_bus immediately after the loading edge.
REQ-014 When out_en=1, x_bus shall be driven with R (combinational from R and out_en, no clock delay).
REQ-015 When out_en=0, every x_bus bit shall be high-impedance (Z).
REQ-016 Load and output enable may be active at the same time. Without the write-through macro, x_bus shall show the old R until the edge and the new R after it.
REQ-017 X or Z on y_bus during a load shall be stored as-is; the block shall not filter it.

Reset
REQ-018 At a ph1 rising edge with reset=1, R shall become all zeros, regardless of in_en.
REQ-019 Reset shall take priority over any load in the same cycle, including a load already in progress in the previous cycle.
REQ-020 Reset shall not affect x_bus drive: with out_en=1 during reset, x_bus shows R, which becomes 0 after the reset edge.
REQ-021 Before the first reset edge R is undefined; there is no asynchronous clear.

Configuration
REQ-022 Macro BUS_FLAG_LATCH_WRITE_THROUGH_EN.
- Defined: while out_en=1, each x_bus bit whose load is currently enabled shall be driven combinationally from y_bus[i] instead of R[i]; bits that are not enabled shall show R[i].
- Not defined: x_bus always shows R (REQ-014), and no combinational path from y_bus to x_bus exists.
REQ-023 The macro shall not change R update behaviour, reset behaviour, or the value output in either setting.

Verification
REQ-024 Reset: reset=1 for 1 edge, y_bus=8'hA5, in_en=all ones -> value=8'h00 after the edge; with out_en=0, x_bus=8'hZZ.
REQ-025 Drive: after reset, out_en=1, in_en=0 -> x_bus=8'h00. Then out_en=0 -> x_bus=8'hZZ in the same cycle.
REQ-026 Incrementing loop: set y_bus = x_bus+1 through an external register clocked on the opposite phase; out_en=1, in_en[0]=1, PER_BIT_EN=0 -> value follows 1, 2, 3, ... on successive ph1 edges.
REQ-027 Per-bit mask: PER_BIT_EN=1, R=8'h00, y_bus=8'hFF, in_en=8'b0111_1110 -> value=8'h7E. Then y_bus=8'h00, in_en=8'h01 -> value=8'h7E, because bit 0 was already 0.
REQ-028 Reset priority: in_en=all ones, y_bus=8'h3C, reset=1 on the same edge -> value=8'h00; the next edge with reset=0 -> value=8'h3C.
REQ-029 Write-through, macro defined: R=8'h10, out_en=1, in_en[0]=1, y_bus=8'h22 -> x_bus=8'h22 before the edge. The same stimulus with the macro undefined -> x_bus=8'h10 before the edge, 8'h22 after it.

Source files
------------

// File: rtl/bus_flag_latch.sv
// Loadable WIDTH-bit register with a tri-state output onto x_bus.
// Optional macro BUS_FLAG_LATCH_WRITE_THROUGH_EN forwards y_bus to x_bus for load-enabled bits.
module bus_flag_latch #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          PER_BIT_EN = 1'b0
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_en,
  input  logic             out_en,
  output logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] y_bus,
  inout  wire  [WIDTH-1:0] x_bus
);

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] load_mask;
  logic [WIDTH-1:0] drive;

  // Bus-register mode broadcasts in_en[0] to every bit.
  assign load_mask = PER_BIT_EN ? in_en : {WIDTH{in_en[0]}};

  // Per-bit select keeps X/Z on y_bus intact rather than masking it through AND/OR.
  always_comb begin
    r_d = r_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (load_mask[i]) r_d[i] = y_bus[i];
    end
  end

  always_ff @(posedge ph1) begin
    if (reset) r_q <= '0;
    else       r_q <= r_d;
  end

`ifdef BUS_FLAG_LATCH_WRITE_THROUGH_EN
  always_comb begin
    drive = r_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (load_mask[i]) drive[i] = y_bus[i];
    end
  end
`else
  assign drive = r_q;
`endif

  assign value = r_q;
  assign x_bus = out_en ? drive : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_flag_latch.sv
// Self-checking bench for bus_flag_latch: both load modes, directed cases and random traffic.
module tb_bus_flag_latch;

  logic       ph1 = 1'b0;
  logic       reset;
  logic [7:0] in_en;
  logic       out_en;
  logic [7:0] y_drv, y_loop, y_bus;
  logic       loop_mode;
  logic       probe_en;
  logic [7:0] probe_val;
  logic [7:0] value0, value1;
  wire  [7:0] x0, x1;

  int checks = 0;
  int errors = 0;

  // Reference register contents for each instance.
  logic [7:0] m0, m1;
  bit         model_valid;

  always #5 ph1 = ~ph1;

  assign y_bus = loop_mode ? y_loop : y_drv;
  assign x0    = probe_en ? probe_val : 8'bz;
  assign x1    = probe_en ? probe_val : 8'bz;

  // External incrementer register on the opposite phase.
  always @(negedge ph1) y_loop <= x0 + 8'd1;

  bus_flag_latch #(.WIDTH(8), .PER_BIT_EN(1'b0)) dut0 (
    .ph1    (ph1),
    .reset  (reset),
    .in_en  (in_en),
    .out_en (out_en),
    .value  (value0),
    .y_bus  (y_bus),
    .x_bus  (x0)
  );

  bus_flag_latch #(.WIDTH(8), .PER_BIT_EN(1'b1)) dut1 (
    .ph1    (ph1),
    .reset  (reset),
    .in_en  (in_en),
    .out_en (out_en),
    .value  (value1),
    .y_bus  (y_bus),
    .x_bus  (x1)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mask_of(input bit per_bit, input logic [7:0] en);
    return per_bit ? en : (en[0] ? 8'hFF : 8'h00);
  endfunction

  function automatic logic [7:0] next_of(input logic [7:0] r, input logic [7:0] m,
                                         input logic [7:0] y, input logic rst);
    if (rst) return 8'h00;
    return (r & ~m) | (y & m);
  endfunction

  function automatic logic [7:0] bus_of(input logic [7:0] r, input logic [7:0] m,
                                        input logic [7:0] y);
`ifdef BUS_FLAG_LATCH_WRITE_THROUGH_EN
    return (r & ~m) | (y & m);
`else
    return r;
`endif
  endfunction

  // With out_en low, an outside driver must own the bus undisturbed.
  task automatic check_bus(input string tag);
    if (out_en) begin
      check({tag, "_x0"}, x0, bus_of(m0, mask_of(1'b0, in_en), y_bus));
      check({tag, "_x1"}, x1, bus_of(m1, mask_of(1'b1, in_en), y_bus));
    end else begin
      probe_en  = 1'b1;
      probe_val = 8'h00;
      #1;
      check({tag, "_z0lo"}, x0, 8'h00);
      check({tag, "_z1lo"}, x1, 8'h00);
      probe_val = 8'hFF;
      #1;
      check({tag, "_z0hi"}, x0, 8'hFF);
      check({tag, "_z1hi"}, x1, 8'hFF);
      probe_en = 1'b0;
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [7:0] en,
                      input logic [7:0] y, input logic oe);
    logic [7:0] n0, n1;
    reset  = rst;
    in_en  = en;
    y_drv  = y;
    out_en = oe;
    #1;
    if (model_valid) check_bus({tag, "_pre"});
    n0 = next_of(m0, mask_of(1'b0, en), y, rst);
    n1 = next_of(m1, mask_of(1'b1, en), y, rst);
    @(posedge ph1);
    m0 = n0;
    m1 = n1;
    model_valid = 1'b1;
    #1;
    check({tag, "_v0"}, value0, m0);
    check({tag, "_v1"}, value1, m1);
    check_bus({tag, "_post"});
  endtask

  initial begin
    reset       = 1'b0;
    in_en       = 8'h00;
    out_en      = 1'b0;
    y_drv       = 8'h00;
    loop_mode   = 1'b0;
    probe_en    = 1'b0;
    probe_val   = 8'h00;
    model_valid = 1'b0;
    m0          = 8'h00;
    m1          = 8'h00;
    @(posedge ph1);
    #1;

    step("reset", 1'b1, 8'hFF, 8'hA5, 1'b0);
    step("drive_on", 1'b0, 8'h00, 8'h5A, 1'b1);
    step("drive_off", 1'b0, 8'h00, 8'h5A, 1'b0);

    step("mask_7e", 1'b0, 8'h7E, 8'hFF, 1'b0);
    check("mask_7e_lit", value1, 8'h7E);
    step("mask_01", 1'b0, 8'h01, 8'h00, 1'b1);
    check("mask_01_lit", value1, 8'h7E);

    step("rst_prio", 1'b1, 8'hFF, 8'h3C, 1'b1);
    check("rst_prio_lit", value0, 8'h00);
    step("after_rst", 1'b0, 8'hFF, 8'h3C, 1'b1);
    check("after_rst_lit", value0, 8'h3C);

    step("wt_setup", 1'b0, 8'h01, 8'h10, 1'b0);
    step("wt", 1'b0, 8'h01, 8'h22, 1'b1);
    check("wt_after_lit", x0, 8'h22);

    for (int i = 0; i < 200; i++) begin
      step("rand", ($urandom_range(15) == 0), 8'($urandom), 8'($urandom),
           1'($urandom_range(1)));
    end

    // Incrementing loop through the negedge register.
    step("loop_rst", 1'b1, 8'h00, 8'h00, 1'b1);
    reset     = 1'b0;
    in_en     = 8'h01;
    out_en    = 1'b1;
    loop_mode = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge ph1);
      #1;
      check($sformatf("loop_%0d", k), value0, 8'(k));
    end
    loop_mode = 1'b0;
    model_valid = 1'b0;
    step("final_rst", 1'b1, 8'hFF, 8'hFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
